// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 memory-select codes, message character set and checker states
package rc4_pkg;

    // Memory handler port selects shared by mem_decrypt, msg_checker and the handler
    localparam logic [1:0] MEM_SEL_NONE    = 2'd0;
    localparam logic [1:0] MEM_SEL_S       = 2'd1;
    localparam logic [1:0] MEM_SEL_ENC_ROM = 2'd2;
    localparam logic [1:0] MEM_SEL_DEC_RAM = 2'd3;

    // Accepted plaintext alphabet: lowercase letters and space
    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [2:0] {
        CHK_IDLE,
        CHK_INIT,
        CHK_SETUP,
        CHK_READ,
        CHK_SAMPLE,
        CHK_CHECK,
        CHK_NEXT,
        CHK_DONE
    } chk_state_t;

endpackage

// File: rtl/char_is_valid.sv
// rtl/char_is_valid.sv - combinational accept test for one plaintext byte
module char_is_valid
    import rc4_pkg::*;
#(
    parameter int         DATA_W  = 8,
    parameter logic [7:0] CHAR_LO = rc4_pkg::CHAR_LO,
    parameter logic [7:0] CHAR_HI = rc4_pkg::CHAR_HI,
    parameter logic [7:0] CHAR_SP = rc4_pkg::CHAR_SP
) (
    input  logic [DATA_W-1:0] data,
    output logic              accept
);

    // A byte passes if it is inside the letter range or is the space code
    always_comb begin
        accept = ((data >= DATA_W'(CHAR_LO)) && (data <= DATA_W'(CHAR_HI)))
              || (data == DATA_W'(CHAR_SP));
    end

endmodule

// File: rtl/msg_checker.sv
// rtl/msg_checker.sv - reads back the decrypted RAM and accepts only lowercase/space messages
module msg_checker
    import rc4_pkg::*;
#(
    parameter int         MSG_LEN_W = 5,
    parameter int         DATA_W    = 8,
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] CHAR_LO   = rc4_pkg::CHAR_LO,
    parameter logic [7:0] CHAR_HI   = rc4_pkg::CHAR_HI,
    parameter logic [7:0] CHAR_SP   = rc4_pkg::CHAR_SP
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_sig,
    input  logic [MSG_LEN_W-1:0] iterations,
    input  logic [DATA_W-1:0]    q_data,
    output logic                 finish,
    output logic                 check_mem_handler,
    output logic [ADDR_W-1:0]    address,
    output logic [1:0]           memory_sel,
    output logic                 wen,
    output logic                 valid,
    output logic [MSG_LEN_W-1:0] bad_index,
    output logic [DATA_W-1:0]    bad_char
);

    chk_state_t           state;
    logic [MSG_LEN_W-1:0] k;
    logic [DATA_W-1:0]    byte_q;
    logic                 byte_ok;

    char_is_valid #(
        .DATA_W  (DATA_W),
        .CHAR_LO (CHAR_LO),
        .CHAR_HI (CHAR_HI),
        .CHAR_SP (CHAR_SP)
    ) u_char_is_valid (
        .data   (byte_q),
        .accept (byte_ok)
    );

    // Handler request lines decode straight from the state register; k only moves on
    // entry to SETUP, so the address is stable across SETUP/READ/SAMPLE
    always_comb begin
        finish            = (state == CHK_DONE);
        check_mem_handler = (state != CHK_IDLE) && (state != CHK_DONE);
        memory_sel        = ((state == CHK_SETUP) || (state == CHK_READ) || (state == CHK_SAMPLE))
                          ? MEM_SEL_DEC_RAM : MEM_SEL_NONE;
        address           = {{(ADDR_W-MSG_LEN_W){1'b0}}, k};
        wen               = 1'b0;
    end

    // Check sequencer: one byte per SETUP..CHECK pass, stopping at the first reject
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CHK_IDLE;
            k         <= '0;
            byte_q    <= '0;
            valid     <= 1'b0;
            bad_index <= '0;
            bad_char  <= '0;
        end else begin
            case (state)
                CHK_IDLE: begin
                    if (start_sig) begin
                        state <= CHK_INIT;
                    end
                end
                CHK_INIT: begin
                    k         <= '0;
                    valid     <= 1'b0;
                    bad_index <= '0;
                    bad_char  <= '0;
                    state     <= CHK_SETUP;
                end
                CHK_SETUP: begin
                    state <= CHK_READ;
                end
                CHK_READ: begin
                    state <= CHK_SAMPLE;
                end
                CHK_SAMPLE: begin
                    byte_q <= q_data;
                    state  <= CHK_CHECK;
                end
                CHK_CHECK: begin
                    if (!byte_ok) begin
                        bad_index <= k;
                        bad_char  <= byte_q;
                        valid     <= 1'b0;
                        state     <= CHK_DONE;
                    end else if (k == iterations) begin
                        valid <= 1'b1;
                        state <= CHK_DONE;
                    end else begin
                        state <= CHK_NEXT;
                    end
                end
                CHK_NEXT: begin
                    k     <= k + 1'b1;
                    state <= CHK_SETUP;
                end
                CHK_DONE: begin
                    state <= CHK_IDLE;
                end
                default: begin
                    state <= CHK_IDLE;
                end
            endcase
        end
    end

endmodule
